// File: rtl/full_fn_pkg.sv
// Shared constants and types for the full-function custom-instruction completion stage.
package full_fn_pkg;

    localparam logic [31:0] FP_QNAN   = 32'h7FC0_0000;
    localparam int          INNER_LAT = 43;
    localparam int          ACC_LAT   = 8;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/full_fn_drain_ctrl_if.sv
// Issue/accumulator/start-done signal bundle between the Nios-side driver and the drain controller.
interface full_fn_drain_ctrl_if #(
    parameter int CNT_W = 6
);
    logic             issue_valid;
    logic             issue_last;
    logic [31:0]      acc_result;
    logic             start;
    logic [31:0]      result;
    logic             done;
    logic             busy;
    logic [CNT_W-1:0] inflight;
    logic             overrun;

    modport master (
        output issue_valid, issue_last, acc_result, start,
        input  result, done, busy, inflight, overrun
    );

    modport slave (
        input  issue_valid, issue_last, acc_result, start,
        output result, done, busy, inflight, overrun
    );
endinterface

// File: rtl/full_fn_tag_delay.sv
// {valid,last} tag shift register matched to the upstream pipeline depth; shifts only on clk_en.
module full_fn_tag_delay #(
    parameter int DEPTH = 51
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clk_en,
    input  logic in_valid,
    input  logic in_last,
    output logic out_valid,
    output logic out_last
);
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [DEPTH-1:0] last_q;
    logic [DEPTH-1:0] last_d;

    // last is only meaningful alongside valid, so it is qualified on entry
    assign valid_d[0] = in_valid;
    assign last_d[0]  = in_valid & in_last;

    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_stage
        assign valid_d[gi] = valid_q[gi-1];
        assign last_d[gi]  = last_q[gi-1];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            last_q  <= '0;
        end else if (clk_en) begin
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_last  = last_q[DEPTH-1];
endmodule

// File: rtl/full_fn_drain_ctrl.sv
// Completion stage: captures the accumulator sum at batch end and returns it via start/done.
// Optional WAIT timeout enabled by defining FULL_FN_DRAIN_TIMEOUT_EN.
module full_fn_drain_ctrl
    import full_fn_pkg::*;
#(
    parameter int TOTAL_LATENCY = INNER_LAT + ACC_LAT,
    parameter int CNT_W         = 6
`ifdef FULL_FN_DRAIN_TIMEOUT_EN
    ,
    parameter int TIMEOUT       = 1023
`endif
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 clk_en,
    full_fn_drain_ctrl_if.slave  bus
);
    localparam logic [0:0] S_IDLE = IDLE;
    localparam logic [0:0] S_WAIT = WAIT;

    logic             tag_valid;
    logic             tag_last;
    logic             capture;
    logic [0:0]       state_q, state_d;
    logic [31:0]      result_q, result_d;
    logic [31:0]      sum_q, sum_d;
    logic             sum_ready_q, sum_ready_d;
    logic             done_q, done_d;
    logic             overrun_q, overrun_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;

    full_fn_tag_delay #(.DEPTH(TOTAL_LATENCY)) u_tag_delay (
        .clock     (clock),
        .reset_n   (reset_n),
        .clk_en    (clk_en),
        .in_valid  (bus.issue_valid),
        .in_last   (bus.issue_last),
        .out_valid (tag_valid),
        .out_last  (tag_last)
    );

    assign capture = tag_valid & tag_last;

`ifdef FULL_FN_DRAIN_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    logic [TMR_W-1:0] timer_q, timer_d;
`endif

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        sum_d       = sum_q;
        sum_ready_d = sum_ready_q;
        done_d      = 1'b0;
        overrun_d   = overrun_q;
`ifdef FULL_FN_DRAIN_TIMEOUT_EN
        timer_d     = timer_q;
`endif

        case ({bus.issue_valid, tag_valid})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase

        if (state_q == S_WAIT) begin
            // sum_ready is known to be clear here, so a capture goes straight out
            if (capture) begin
                done_d   = 1'b1;
                result_d = bus.acc_result;
                state_d  = S_IDLE;
            end
`ifdef FULL_FN_DRAIN_TIMEOUT_EN
            else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                done_d   = 1'b1;
                result_d = FP_QNAN;
                state_d  = S_IDLE;
            end else begin
                timer_d = timer_q + TMR_W'(1);
            end
`endif
        end else if (capture && bus.start) begin
            done_d      = 1'b1;
            result_d    = bus.acc_result;
            sum_ready_d = 1'b0;
        end else if (capture) begin
            sum_d       = bus.acc_result;
            sum_ready_d = 1'b1;
            if (sum_ready_q) overrun_d = 1'b1;
        end else if (bus.start) begin
            if (sum_ready_q) begin
                done_d      = 1'b1;
                result_d    = sum_q;
                sum_ready_d = 1'b0;
            end else if (inflight_q != '0) begin
                state_d = S_WAIT;
`ifdef FULL_FN_DRAIN_TIMEOUT_EN
                timer_d = '0;
`endif
            end else begin
                done_d   = 1'b1;
                result_d = FP_QNAN;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            result_q    <= '0;
            sum_q       <= '0;
            sum_ready_q <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
            inflight_q  <= '0;
        end else if (clk_en) begin
            state_q     <= state_d;
            result_q    <= result_d;
            sum_q       <= sum_d;
            sum_ready_q <= sum_ready_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
            inflight_q  <= inflight_d;
        end
    end

`ifdef FULL_FN_DRAIN_TIMEOUT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)    timer_q <= '0;
        else if (clk_en) timer_q <= timer_d;
    end
`endif

    assign bus.result   = result_q;
    assign bus.done     = done_q;
    assign bus.busy     = (inflight_q != '0);
    assign bus.inflight = inflight_q;
    assign bus.overrun  = overrun_q;
endmodule
